// File: rtl/packet_tx_mux_pkg.sv
// Shared monitor-link definitions: serialiser state encoding and default packet width.
package packet_tx_mux_pkg;

  localparam int unsigned LINK_PKT_W = 40;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    GAP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         mon_clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [DEPTH];

  // Equal index with differing wrap bit means the writer is a full lap ahead.
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge mon_clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop && !empty) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge mon_clk) begin
    if (!reset && push && !full) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/packet_tx_mux.sv
// Multi-producer monitor-link transmitter: per-channel FIFOs, arbiter, serialiser
// and saturating loss counter.
module packet_tx_mux
  import packet_tx_mux_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PKT_W      = LINK_PKT_W,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned GAP_BITS   = 2,
  parameter int unsigned RR_MODE    = 1,
  parameter int unsigned LOSS_W     = 8
) (
  input  logic                    mon_clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req_valid,
  input  logic [N_CH*PKT_W-1:0]   req_data,
  output logic                    from_mon,
  output logic                    busy,
  output logic [N_CH-1:0]         ch_full,
  output logic [N_CH-1:0]         data_loss,
  output logic [LOSS_W-1:0]       loss_count
);

  localparam int unsigned PW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BMAX = (PKT_W > GAP_BITS) ? PKT_W : GAP_BITS;
  localparam int unsigned BW   = $clog2(BMAX + 1);
  localparam int unsigned DW   = $clog2(N_CH + 1);
  localparam int unsigned LSW  = LOSS_W + DW;

  tx_state_e          state_q;
  logic [PKT_W-1:0]   shift_q;
  logic [CW-1:0]      cyc_q;
  logic [BW-1:0]      bit_q;
  logic [PW-1:0]      rr_q;
  logic               from_mon_q;
  logic               busy_q;
  logic [N_CH-1:0]    data_loss_q;
  logic [LOSS_W-1:0]  loss_q;
  logic [LOSS_W-1:0]  loss_d;

  logic [N_CH-1:0]    fifo_full;
  logic [N_CH-1:0]    fifo_empty;
  logic [N_CH-1:0]    pop_sel;
  logic [PKT_W-1:0]   fifo_dout [N_CH];
  logic [N_CH-1:0]    drop;
  logic [DW-1:0]      drop_cnt;
  logic [LSW-1:0]     loss_sum;
  logic               grant_vld;
  logic [PW-1:0]      grant_idx;
  logic [PW:0]        cand;
  logic               bit_end;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sync_fifo #(
      .W     (PKT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .mon_clk (mon_clk),
      .reset   (reset),
      .push    (req_valid[c]),
      .din     (req_data[c*PKT_W +: PKT_W]),
      .pop     (pop_sel[c]),
      .dout    (fifo_dout[c]),
      .full    (fifo_full[c]),
      .empty   (fifo_empty[c])
    );
  end

  // Search starts at rr_q in round-robin mode and at channel 0 otherwise.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = ((RR_MODE != 0) ? {1'b0, rr_q} : '0) + (PW+1)'(i);
      if (cand >= (PW+1)'(N_CH)) begin
        cand = cand - (PW+1)'(N_CH);
      end
      if (!grant_vld && !fifo_empty[cand[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    pop_sel = '0;
    if (state_q == IDLE && grant_vld) begin
      pop_sel[grant_idx] = 1'b1;
    end
  end

  assign bit_end = (cyc_q == CW'(BIT_CYCLES - 1));

  always_ff @(posedge mon_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cyc_q      <= '0;
      bit_q      <= '0;
      rr_q       <= '0;
      from_mon_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_vld) begin
            shift_q    <= fifo_dout[grant_idx];
            cyc_q      <= '0;
            from_mon_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= START;
            if (RR_MODE != 0) begin
              rr_q <= (grant_idx == PW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
          end
        end
        START: begin
          if (bit_end) begin
            cyc_q      <= '0;
            bit_q      <= BW'(PKT_W - 1);
            from_mon_q <= shift_q[PKT_W-1];
            state_q    <= DATA;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == '0) begin
              from_mon_q <= 1'b0;
              if (GAP_BITS == 0) begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                bit_q   <= BW'(GAP_BITS - 1);
                state_q <= GAP;
              end
            end else begin
              bit_q      <= bit_q - 1'b1;
              shift_q    <= shift_q << 1;
              from_mon_q <= shift_q[PKT_W-2];
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        GAP: begin
          if (bit_end) begin
            cyc_q <= '0;
            if (bit_q == '0) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              bit_q <= bit_q - 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Fullness is sampled before any pop this cycle, so a same-cycle pop never rescues a push.
  assign drop = req_valid & fifo_full;

  always_comb begin
    drop_cnt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      drop_cnt = drop_cnt + DW'(drop[i]);
    end
    loss_sum = LSW'(loss_q) + LSW'(drop_cnt);
    loss_d   = (loss_sum > LSW'({LOSS_W{1'b1}})) ? '1 : loss_sum[LOSS_W-1:0];
  end

  always_ff @(posedge mon_clk) begin
    if (reset) begin
      data_loss_q <= '0;
      loss_q      <= '0;
    end else begin
      data_loss_q <= drop;
      loss_q      <= loss_d;
    end
  end

  assign from_mon   = from_mon_q;
  assign busy       = busy_q;
  assign ch_full    = fifo_full;
  assign data_loss  = data_loss_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_packet_tx_mux.sv
// Bench for packet_tx_mux: two configurations, each checked every cycle against a
// queue-based frame model, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_packet_tx_mux;

  localparam int NC = 4;
  localparam int PW = 40;
  localparam int DP = 2;
  typedef logic [PW-1:0] pkt_t;

  localparam logic [3:0] S6_RV [7] = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0001, 4'b0010};
  localparam logic [7:0] S6_LC [7] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
  localparam logic [3:0] S6_DL [7] = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0011, 4'b0001, 4'b0010};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst [2];
  logic [NC-1:0]    rv  [2];
  logic [NC*PW-1:0] rd  [2];
  logic             fm  [2];
  logic             bz  [2];
  logic [NC-1:0]    cf  [2];
  logic [NC-1:0]    dl  [2];
  logic [7:0]       lc  [2];
  int               glog [2][$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Config 0: round-robin, 1 cycle/bit, 2 gap bits, 8-bit loss counter.
  // Config 1: fixed priority, 2 cycles/bit, no gap, 2-bit loss counter.
  for (genvar k = 0; k < 2; k++) begin : g_cfg
    localparam int RR   = (k == 0) ? 1 : 0;
    localparam int BC   = (k == 0) ? 1 : 2;
    localparam int GP   = (k == 0) ? 2 : 0;
    localparam int LW   = (k == 0) ? 8 : 2;
    localparam int LMAX = (1 << LW) - 1;

    logic [LW-1:0] lc_k;

    packet_tx_mux #(
      .N_CH       (NC),
      .PKT_W      (PW),
      .DEPTH      (DP),
      .BIT_CYCLES (BC),
      .GAP_BITS   (GP),
      .RR_MODE    (RR),
      .LOSS_W     (LW)
    ) u_dut (
      .mon_clk    (clk),
      .reset      (rst[k]),
      .req_valid  (rv[k]),
      .req_data   (rd[k]),
      .from_mon   (fm[k]),
      .busy       (bz[k]),
      .ch_full    (cf[k]),
      .data_loss  (dl[k]),
      .loss_count (lc_k)
    );
    assign lc[k] = 8'(lc_k);

    pkt_t          mq [NC][$];
    logic [1:0]    stream [$];   // {busy, line} for each upcoming cycle of the current frame
    int            rr_m;
    int            loss_m;
    logic [1:0]    exp_out;
    logic [NC-1:0] exp_dl;
    bit            armed = 1'b0;

    always @(posedge clk) begin
      bit   full_pre [NC];
      int   g;
      int   c;
      pkt_t p;
      if (rst[k]) begin
        for (int i = 0; i < NC; i++) mq[i].delete();
        stream.delete();
        rr_m    = 0;
        loss_m  = 0;
        exp_out = 2'b00;
        exp_dl  = '0;
        armed   = 1'b1;
      end else begin
        for (int i = 0; i < NC; i++) full_pre[i] = (mq[i].size() == DP);
        exp_dl = '0;
        if (stream.size() != 0) begin
          exp_out = stream.pop_front();
        end else begin
          g = -1;
          for (int i = 0; i < NC; i++) begin
            c = (RR != 0) ? (rr_m + i) % NC : i;
            if (g < 0 && mq[c].size() != 0) g = c;
          end
          if (g >= 0) begin
            p = mq[g].pop_front();
            glog[k].push_back(g);
            rr_m = (g + 1) % NC;
            repeat (BC) stream.push_back(2'b11);
            for (int b = PW - 1; b >= 0; b--) repeat (BC) stream.push_back({1'b1, p[b]});
            repeat (GP * BC) stream.push_back(2'b10);
            stream.push_back(2'b00);
            exp_out = stream.pop_front();
          end else begin
            exp_out = 2'b00;
          end
        end
        for (int i = 0; i < NC; i++) begin
          if (rv[k][i]) begin
            if (full_pre[i]) begin
              exp_dl[i] = 1'b1;
              loss_m++;
            end else begin
              mq[i].push_back(rd[k][i*PW +: PW]);
            end
          end
        end
        if (loss_m > LMAX) loss_m = LMAX;
      end
    end

    always @(negedge clk) begin
      logic [NC-1:0] ef;
      if (armed) begin
        for (int i = 0; i < NC; i++) ef[i] = (mq[i].size() == DP);
        check($sformatf("cfg%0d from_mon", k), 64'(fm[k]), 64'(exp_out[0]));
        check($sformatf("cfg%0d busy", k), 64'(bz[k]), 64'(exp_out[1]));
        check($sformatf("cfg%0d ch_full", k), 64'(cf[k]), 64'(ef));
        check($sformatf("cfg%0d data_loss", k), 64'(dl[k]), 64'(exp_dl));
        check($sformatf("cfg%0d loss_count", k), 64'(lc[k]), 64'(loss_m));
      end
    end
  end

  initial begin
    logic [44:0] cap;
    logic [PW-1:0] dat;
    logic [19:0] ord;
    int bcnt;
    int t;
    int base;

    for (int kk = 0; kk < 2; kk++) begin
      rst[kk] = 1'b1;
      rv[kk]  = '0;
      rd[kk]  = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame: start bit, 40 bits MSB first, two gap bits.
    rd[0] = '0;
    rd[0][PW-1:0] = 40'hA5_0000_0001;
    rv[0] = 4'b0001;
    @(negedge clk);
    rv[0] = '0;
    check("s1 line low in grant cycle", 64'(fm[0]), 64'd0);
    check("s1 busy low in grant cycle", 64'(bz[0]), 64'd0);
    bcnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      cap[i] = fm[0];
      if (bz[0] === 1'b1) bcnt++;
    end
    dat = '0;
    for (int j = 0; j < PW; j++) dat = {dat[PW-2:0], cap[1+j]};
    check("s1 start bit", 64'(cap[0]), 64'd1);
    check("s1 data bits", 64'(dat), 64'hA5_0000_0001);
    check("s1 gap and idle", 64'(cap[44:41]), 64'd0);
    check("s1 busy cycles", 64'(bcnt), 64'd43);

    // Four back-to-back pushes on ch1 with depth 2: the fourth is dropped.
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      rv[0] = (i < 4) ? 4'b0010 : 4'b0000;
      rd[0] = '0;
      rd[0][PW +: PW] = PW'(64'h11_0000_0000 + 64'(i));
      @(negedge clk);
      if (dl[0][1] === 1'b1) bcnt++;
    end
    check("s2 data_loss pulses", 64'(bcnt), 64'd1);
    check("s2 loss_count", 64'(lc[0]), 64'd1);
    repeat (200) @(negedge clk);
    ord = '0;
    for (int i = 1; i < glog[0].size(); i++) ord = (ord << 4) | 20'(glog[0][i]);
    check("s2 frames emitted", 64'(glog[0].size()), 64'd4);
    check("s2 grant order", 64'(ord), 64'h111);

    // Round-robin: ch0, ch2, ch3 loaded together, then ch0/ch2 refilled during ch3.
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    glog[0].delete();
    rd[0] = {40'h33_0000_0003, 40'h33_0000_0002, 40'h0, 40'h33_0000_0000};
    rv[0] = 4'b1101;
    @(negedge clk);
    rv[0] = '0;
    t = 0;
    while (glog[0].size() < 3 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("s3 wait for ch3 grant", 64'(glog[0].size()), 64'd3);
    rd[0] = {40'h0, 40'h44_0000_0002, 40'h0, 40'h44_0000_0000};
    rv[0] = 4'b0101;
    @(negedge clk);
    rv[0] = '0;
    repeat (200) @(negedge clk);
    ord = '0;
    for (int i = 0; i < glog[0].size(); i++) ord = (ord << 4) | 20'(glog[0][i]);
    check("s3 rr grant order", 64'(ord), 64'h02302);

    // Fixed priority: ch1 arriving during the ch0 frame overtakes ch2 and ch3.
    rd[1] = {40'h55_0000_0003, 40'h55_0000_0002, 40'h0, 40'h55_0000_0000};
    rv[1] = 4'b1101;
    @(negedge clk);
    rv[1] = '0;
    t = 0;
    while (glog[1].size() < 1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("s4 wait for ch0 grant", 64'(glog[1].size()), 64'd1);
    rd[1] = {40'h0, 40'h0, 40'h55_0000_0001, 40'h0};
    rv[1] = 4'b0010;
    @(negedge clk);
    rv[1] = '0;
    repeat (420) @(negedge clk);
    ord = '0;
    for (int i = 0; i < glog[1].size(); i++) ord = (ord << 4) | 20'(glog[1][i]);
    check("s4 fixed-priority order", 64'(ord), 64'h0123);

    // Reset in the middle of a data phase kills the frame and the queued packets.
    base = glog[0].size();
    rd[0] = {40'h0, 40'h66_0000_0002, 40'h66_0000_0001, 40'h66_0000_0000};
    rv[0] = 4'b0111;
    @(negedge clk);
    @(negedge clk);
    rv[0] = '0;
    t = 0;
    while (glog[0].size() <= base && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("s5 wait for grant", 64'(glog[0].size()), 64'(base + 1));
    repeat (11) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("s5 from_mon after reset", 64'(fm[0]), 64'd0);
    check("s5 busy after reset", 64'(bz[0]), 64'd0);
    check("s5 ch_full after reset", 64'(cf[0]), 64'd0);
    base = glog[0].size();
    bcnt = 0;
    repeat (120) begin
      @(negedge clk);
      if (bz[0] !== 1'b0) bcnt++;
    end
    check("s5 no busy after reset", 64'(bcnt), 64'd0);
    check("s5 no frames after reset", 64'(glog[0].size()), 64'(base));

    // 2-bit loss counter saturation with simultaneous drops.
    for (int i = 0; i < 7; i++) begin
      rv[1] = S6_RV[i];
      for (int w = 0; w < NC * PW / 32; w++) rd[1][w*32 +: 32] = $urandom;
      @(negedge clk);
      check($sformatf("s6 loss_count step %0d", i), 64'(lc[1]), 64'(S6_LC[i]));
      check($sformatf("s6 data_loss step %0d", i), 64'(dl[1]), 64'(S6_DL[i]));
    end
    rv[1] = '0;
    repeat (300) @(negedge clk);

    // Random traffic with occasional resets on both configurations.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int kk = 0; kk < 2; kk++) begin
        for (int c = 0; c < NC; c++) rv[kk][c] = ($urandom_range(0, 39) == 0);
        for (int w = 0; w < NC * PW / 32; w++) rd[kk][w*32 +: 32] = $urandom;
        rst[kk] = ($urandom_range(0, 999) == 0);
      end
      @(negedge clk);
    end
    for (int kk = 0; kk < 2; kk++) begin
      rv[kk]  = '0;
      rst[kk] = 1'b0;
    end
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
